// File: rtl/video_timing_pkg.sv
// ============================================================================
// video_timing_pkg : default VGA timing, derived raster sizes, coordinate type
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package video_timing_pkg;

  localparam int DEF_H_VISIBLE    = 640;
  localparam int DEF_H_FRONT      = 16;
  localparam int DEF_H_SYNC       = 96;
  localparam int DEF_H_BACK       = 48;
  localparam int DEF_V_VISIBLE    = 480;
  localparam int DEF_V_FRONT      = 10;
  localparam int DEF_V_SYNC       = 2;
  localparam int DEF_V_BACK       = 33;
  localparam int DEF_PIXEL_REPEAT = 2;
  localparam int DEF_LINE_REPEAT  = 2;

  localparam int COORD_W   = 9;
  localparam int COORD_MAX = (1 << COORD_W) - 1;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic int h_total(input int visible, input int front,
                                 input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  function automatic int v_total(input int visible, input int front,
                                 input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  // Last logical coordinate: ceil(total / rep) - 1. A zero repeat is
  // rejected at elaboration; returning total-1 just avoids a divide by zero.
  function automatic int max_coord(input int total, input int rep);
    if (rep < 1) begin
      return total - 1;
    end
    return (total + rep - 1) / rep - 1;
  endfunction

  function automatic int max_x(input int total, input int pixel_repeat);
    return max_coord(total, pixel_repeat);
  endfunction

  function automatic int max_y(input int total, input int line_repeat);
    return max_coord(total, line_repeat);
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/video_timing_wrap_counter.sv
// ============================================================================
// wrap_counter : modulo-N up counter with increment enable, clear and wrap flag
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module wrap_counter #(
  parameter int N     = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

  assign wrap = en && (count == LAST);

  // Clear outranks increment so a group cut short by the line end restarts.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/video_timing.sv
// ============================================================================
// video_timing : VGA raster timing generator with logical pixel coordinates.
// Optional vblank interrupt latch enabled by macro VIDEO_TIMING_VBLANK_IRQ_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module video_timing
  import video_timing_pkg::*;
#(
  parameter int H_VISIBLE    = DEF_H_VISIBLE,
  parameter int H_FRONT      = DEF_H_FRONT,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BACK       = DEF_H_BACK,
  parameter int V_VISIBLE    = DEF_V_VISIBLE,
  parameter int V_FRONT      = DEF_V_FRONT,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BACK       = DEF_V_BACK,
  parameter int PIXEL_REPEAT = DEF_PIXEL_REPEAT,
  parameter int LINE_REPEAT  = DEF_LINE_REPEAT
) (
  input  logic       gpu_clk,
  input  logic       rst,
  output logic [8:0] current_x,
  output logic [8:0] current_y,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
  ,
  input  logic       irq_ack,
  output logic       vblank_irq
`endif
);

  localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int MAX_X   = max_x(H_TOTAL, PIXEL_REPEAT);
  localparam int MAX_Y   = max_y(V_TOTAL, LINE_REPEAT);

  localparam int H_W  = cnt_width(H_TOTAL);
  localparam int V_W  = cnt_width(V_TOTAL);
  localparam int XR_W = cnt_width(PIXEL_REPEAT);
  localparam int YR_W = cnt_width(LINE_REPEAT);

  // One spare bit so an interval ending exactly at the total still compares.
  localparam logic [H_W:0] H_VIS_END = (H_W+1)'(H_VISIBLE);
  localparam logic [H_W:0] HS_BEG    = (H_W+1)'(H_VISIBLE + H_FRONT);
  localparam logic [H_W:0] HS_END    = (H_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [V_W:0] V_VIS_END = (V_W+1)'(V_VISIBLE);
  localparam logic [V_W:0] VS_BEG    = (V_W+1)'(V_VISIBLE + V_FRONT);
  localparam logic [V_W:0] VS_END    = (V_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);

  generate
    if (PIXEL_REPEAT < 1) begin : g_err_pixel_repeat
      $error("video_timing: PIXEL_REPEAT must be at least 1");
    end
    if (LINE_REPEAT < 1) begin : g_err_line_repeat
      $error("video_timing: LINE_REPEAT must be at least 1");
    end
    if (MAX_X > COORD_MAX) begin : g_err_max_x
      $error("video_timing: MAX_X exceeds the 9-bit coordinate range");
    end
    if (MAX_Y > COORD_MAX) begin : g_err_max_y
      $error("video_timing: MAX_Y exceeds the 9-bit coordinate range");
    end
  endgenerate

  logic [H_W-1:0]  w_h;
  logic [V_W-1:0]  w_v;
  logic [XR_W-1:0] w_x_rep;
  logic [YR_W-1:0] w_y_rep;
  coord_t          w_x;
  coord_t          w_y;
  logic            w_h_wrap;
  logic            w_frame_wrap;
  logic            w_x_rep_wrap;
  logic            w_y_rep_wrap;
  logic            w_x_wrap;
  logic            w_y_wrap;
  logic            w_unused;
  logic            w_h_zero;
  logic            w_frame_pos;
  logic            w_hs_active;
  logic            w_vs_active;
  logic            w_vis;
  logic            r_first_frame;

  wrap_counter #(.N(H_TOTAL), .WIDTH(H_W)) u_h_count (
    .clk   (gpu_clk),
    .rst   (rst),
    .en    (1'b1),
    .clr   (1'b0),
    .count (w_h),
    .wrap  (w_h_wrap)
  );

  wrap_counter #(.N(V_TOTAL), .WIDTH(V_W)) u_v_count (
    .clk   (gpu_clk),
    .rst   (rst),
    .en    (w_h_wrap),
    .clr   (1'b0),
    .count (w_v),
    .wrap  (w_frame_wrap)
  );

  wrap_counter #(.N(PIXEL_REPEAT), .WIDTH(XR_W)) u_x_rep (
    .clk   (gpu_clk),
    .rst   (rst),
    .en    (1'b1),
    .clr   (w_h_wrap),
    .count (w_x_rep),
    .wrap  (w_x_rep_wrap)
  );

  wrap_counter #(.N(MAX_X + 1), .WIDTH(COORD_W)) u_x_count (
    .clk   (gpu_clk),
    .rst   (rst),
    .en    (w_x_rep_wrap),
    .clr   (w_h_wrap),
    .count (w_x),
    .wrap  (w_x_wrap)
  );

  wrap_counter #(.N(LINE_REPEAT), .WIDTH(YR_W)) u_y_rep (
    .clk   (gpu_clk),
    .rst   (rst),
    .en    (w_h_wrap),
    .clr   (w_frame_wrap),
    .count (w_y_rep),
    .wrap  (w_y_rep_wrap)
  );

  wrap_counter #(.N(MAX_Y + 1), .WIDTH(COORD_W)) u_y_count (
    .clk   (gpu_clk),
    .rst   (rst),
    .en    (w_y_rep_wrap),
    .clr   (w_frame_wrap),
    .count (w_y),
    .wrap  (w_y_wrap)
  );

  // Coordinate counters are always cleared before they could wrap.
  assign w_unused = &{1'b0, w_x_wrap, w_y_wrap, w_x_rep, w_y_rep};

  assign w_h_zero    = (w_h == '0);
  assign w_frame_pos = w_h_zero && (w_v == '0);
  assign w_hs_active = ({1'b0, w_h} >= HS_BEG) && ({1'b0, w_h} < HS_END);
  assign w_vs_active = ({1'b0, w_v} >= VS_BEG) && ({1'b0, w_v} < VS_END);
  assign w_vis       = ({1'b0, w_h} < H_VIS_END) && ({1'b0, w_v} < V_VIS_END);

  // All outputs decode the same counter snapshot one cycle late, so they
  // stay coherent with each other.
  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      current_x     <= '0;
      current_y     <= '0;
      hsync         <= 1'b1;
      vsync         <= 1'b1;
      visible       <= 1'b0;
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
      frame_count   <= 8'd0;
      r_first_frame <= 1'b1;
    end else begin
      current_x   <= w_x;
      current_y   <= w_y;
      hsync       <= !w_hs_active;
      vsync       <= !w_vs_active;
      visible     <= w_vis;
      line_start  <= w_h_zero;
      frame_start <= w_frame_pos;
      if (w_frame_pos) begin
        if (r_first_frame) begin
          r_first_frame <= 1'b0;
        end else begin
          frame_count <= frame_count + 8'd1;
        end
      end
    end
  end

`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
  localparam logic [V_W-1:0] V_IRQ_LINE = V_W'(V_VISIBLE);

  // A new vblank outranks a simultaneous acknowledge.
  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      vblank_irq <= 1'b0;
    end else if (w_h_zero && (w_v == V_IRQ_LINE)) begin
      vblank_irq <= 1'b1;
    end else if (irq_ack) begin
      vblank_irq <= 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_video_timing.sv
// ============================================================================
// tb_video_timing : directed, self-checking bench for video_timing
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_video_timing;

  localparam int SH_TOT = 16;   // small raster: 8+2+3+3 dots
  localparam int SV_TOT = 11;   // 6+1+2+2 lines, odd total
  localparam int SV_VIS = 6;
  localparam int FRAME  = SH_TOT * SV_TOT;

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic       hs;
    logic       vs;
    logic       vis;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
    logic       irq;
  } obs_t;

  typedef struct {
    logic rst;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s, rst_d, ack_s;
  logic [8:0] x_s, y_s, x_d, y_d;
  logic       hs_s, vs_s, vis_s, ls_s, fs_s, irq_s;
  logic       hs_d, vs_d, vis_d, ls_d, fs_d, irq_d;
  logic [7:0] fc_s, fc_d;

  int checks   = 0;
  int failures = 0;

  int   ch, cv, m_fc;
  logic m_first, m_irq;

  video_timing #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .PIXEL_REPEAT(2), .LINE_REPEAT(2)
  ) dut_s (
    .gpu_clk(clk), .rst(rst_s), .current_x(x_s), .current_y(y_s),
    .hsync(hs_s), .vsync(vs_s), .visible(vis_s), .line_start(ls_s),
    .frame_start(fs_s), .frame_count(fc_s)
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
    , .irq_ack(ack_s), .vblank_irq(irq_s)
`endif
  );

  video_timing dut_d (
    .gpu_clk(clk), .rst(rst_d), .current_x(x_d), .current_y(y_d),
    .hsync(hs_d), .vsync(vs_d), .visible(vis_d), .line_start(ls_d),
    .frame_start(fs_d), .frame_count(fc_d)
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
    , .irq_ack(1'b0), .vblank_irq(irq_d)
`endif
  );

`ifndef VIDEO_TIMING_VBLANK_IRQ_EN
  assign irq_s = 1'b0;
  assign irq_d = 1'b0;
`endif

  function automatic obs_t mk(input int x, input int y, input logic hs, input logic vs,
                              input logic vis, input logic ls, input logic fs, input int fc);
    obs_t o;
    o.x = 9'(x); o.y = 9'(y); o.hs = hs; o.vs = vs; o.vis = vis;
    o.ls = ls; o.fs = fs; o.fc = 8'(fc); o.irq = 1'b0;
    return o;
  endfunction

  function automatic obs_t obs_s();
    obs_t o;
    o.x = x_s; o.y = y_s; o.hs = hs_s; o.vs = vs_s; o.vis = vis_s;
    o.ls = ls_s; o.fs = fs_s; o.fc = fc_s; o.irq = irq_s;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // One clock of the small instance plus the reference model of what it must show.
  task automatic step(input logic r, input logic a, output obs_t got, output obs_t exp);
    rst_s = r;
    ack_s = a;
    @(posedge clk);
    @(negedge clk);
    got = obs_s();
    if (r) begin
      ch = 0; cv = 0; m_first = 1'b1; m_fc = 0; m_irq = 1'b0;
      exp = mk(0, 0, 1, 1, 0, 0, 0, 0);
    end else begin
      exp = mk(ch / 2, cv / 2, !(ch >= 10 && ch < 13), !(cv >= 7 && cv < 9),
               (ch < 8) && (cv < SV_VIS), ch == 0, (ch == 0) && (cv == 0), 0);
      if (exp.fs) begin
        if (m_first) m_first = 1'b0;
        else m_fc = (m_fc + 1) % 256;
      end
      exp.fc = 8'(m_fc);
      if (ch == 0 && cv == SV_VIS) m_irq = 1'b1;
      else if (a) m_irq = 1'b0;
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
      exp.irq = m_irq;
`endif
      ch++;
      if (ch == SH_TOT) begin
        ch = 0;
        cv = (cv + 1) % SV_TOT;
      end
    end
  endtask

  initial begin
    vec_t tbl[20];
    obs_t got, exp;
    int   mism;
    int   hold[6];
    int   vs_low, hs_low, fs_cnt, vis_bad, fs_seen;
    logic done;
    int   first_low, last_low, ls_cnt, ls_k1, ls_k2, x_bad, vis_bad_d, vs_bad;
    logic [8:0] x_798, x_799, x_800;

    rst_s = 1'b1; rst_d = 1'b1; ack_s = 1'b0;

    // Reset, then first line of the small raster, hand-computed.
    tbl[0]  = '{1'b1, mk(0, 0, 1, 1, 0, 0, 0, 0)};
    tbl[1]  = '{1'b1, mk(0, 0, 1, 1, 0, 0, 0, 0)};
    tbl[2]  = '{1'b0, mk(0, 0, 1, 1, 1, 1, 1, 0)};
    tbl[3]  = '{1'b0, mk(0, 0, 1, 1, 1, 0, 0, 0)};
    tbl[4]  = '{1'b0, mk(1, 0, 1, 1, 1, 0, 0, 0)};
    tbl[5]  = '{1'b0, mk(1, 0, 1, 1, 1, 0, 0, 0)};
    tbl[6]  = '{1'b0, mk(2, 0, 1, 1, 1, 0, 0, 0)};
    tbl[7]  = '{1'b0, mk(2, 0, 1, 1, 1, 0, 0, 0)};
    tbl[8]  = '{1'b0, mk(3, 0, 1, 1, 1, 0, 0, 0)};
    tbl[9]  = '{1'b0, mk(3, 0, 1, 1, 1, 0, 0, 0)};
    tbl[10] = '{1'b0, mk(4, 0, 1, 1, 0, 0, 0, 0)};
    tbl[11] = '{1'b0, mk(4, 0, 1, 1, 0, 0, 0, 0)};
    tbl[12] = '{1'b0, mk(5, 0, 0, 1, 0, 0, 0, 0)};
    tbl[13] = '{1'b0, mk(5, 0, 0, 1, 0, 0, 0, 0)};
    tbl[14] = '{1'b0, mk(6, 0, 0, 1, 0, 0, 0, 0)};
    tbl[15] = '{1'b0, mk(6, 0, 1, 1, 0, 0, 0, 0)};
    tbl[16] = '{1'b0, mk(7, 0, 1, 1, 0, 0, 0, 0)};
    tbl[17] = '{1'b0, mk(7, 0, 1, 1, 0, 0, 0, 0)};
    tbl[18] = '{1'b0, mk(0, 0, 1, 1, 1, 1, 0, 0)};
    tbl[19] = '{1'b0, mk(0, 0, 1, 1, 1, 0, 0, 0)};

    for (int i = 0; i < 20; i++) begin
      rst_s = tbl[i].rst;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), 64'(obs_s()), 64'(tbl[i].exp));
    end

    // Three full frames against the model, with irq acknowledges.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, got, exp);
      check($sformatf("reset_b%0d", i), 64'(got), 64'(mk(0, 0, 1, 1, 0, 0, 0, 0)));
    end
    mism = 0; vs_low = 0; hs_low = 0; fs_cnt = 0; vis_bad = 0;
    for (int i = 0; i < 6; i++) hold[i] = 0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      logic a;
      a = (k == FRAME + 96) || (k % FRAME == 116);
      step(1'b0, a, got, exp);
      if (got !== exp) begin
        if (mism == 0) $display("first model difference at sample %0d: 0x%0h vs 0x%0h", k, got, exp);
        mism++;
      end
      if (k >= FRAME && k < 2 * FRAME) begin
        if (!got.vs) vs_low++;
        if (!got.hs) hs_low++;
        if (got.fs) fs_cnt++;
        if (got.vis && got.y >= 3) vis_bad++;
        if (got.y < 6) hold[got.y]++;
      end
      if (k == FRAME - 1) check("fc_before_2nd_frame", 64'(got.fc), 64'd0);
      if (k == FRAME)     check("fc_at_2nd_frame", 64'(got.fc), 64'd1);
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
      if (k == 95)          check("irq_before_set", 64'(got.irq), 64'd0);
      if (k == 96)          check("irq_set_line6", 64'(got.irq), 64'd1);
      if (k == 115)         check("irq_held", 64'(got.irq), 64'd1);
      if (k == 116)         check("irq_acked", 64'(got.irq), 64'd0);
      if (k == FRAME + 95)  check("irq_idle", 64'(got.irq), 64'd0);
      if (k == FRAME + 96)  check("irq_set_beats_ack", 64'(got.irq), 64'd1);
`endif
    end
    check("stream_frames", 64'(mism), 64'd0);
    check("vsync_low_cycles", 64'(vs_low), 64'd32);
    check("hsync_low_cycles", 64'(hs_low), 64'd33);
    check("frame_start_per_frame", 64'(fs_cnt), 64'd1);
    check("visible_in_blank_rows", 64'(vis_bad), 64'd0);
    for (int i = 0; i < 6; i++)
      check($sformatf("y%0d_hold", i), 64'(hold[i]), (i == 5) ? 64'd16 : 64'd32);

    // Reset asserted mid-frame at line 4, dot 7.
    mism = 0;
    for (int k = 0; k < 4 * SH_TOT + 8; k++) begin
      step(1'b0, 1'b0, got, exp);
      if (got !== exp) mism++;
    end
    check("stream_pre_reset", 64'(mism), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, got, exp);
      check($sformatf("midreset_%0d", i), 64'(got), 64'(mk(0, 0, 1, 1, 0, 0, 0, 0)));
    end
    step(1'b0, 1'b0, got, exp);
    check("after_release", 64'(got), 64'(mk(0, 0, 1, 1, 1, 1, 1, 0)));

    // frame_count wrap: 257th frame_start since reset reads 0 again.
    mism = 0; fs_seen = 1; done = 1'b0;
    for (int k = 0; k < 258 * FRAME && !done; k++) begin
      step(1'b0, 1'b0, got, exp);
      if (got !== exp) mism++;
      if (got.fs) begin
        fs_seen++;
        if (fs_seen == 256) check("fc_255", 64'(got.fc), 64'd255);
        if (fs_seen == 257) begin
          check("fc_wrap_0", 64'(got.fc), 64'd0);
          done = 1'b1;
        end
      end
    end
    check("fc_wrap_reached", 64'(fs_seen), 64'd257);
    check("stream_wrap", 64'(mism), 64'd0);

    // Default 640x480 instance: first full line plus one sample.
    first_low = -1; last_low = -1; hs_low = 0; ls_cnt = 0; ls_k1 = 0; ls_k2 = 0;
    x_bad = 0; vis_bad_d = 0; vs_bad = 0; x_798 = '0; x_799 = '0; x_800 = '1;
    rst_d = 1'b0;
    for (int k = 1; k <= 801; k++) begin
      int h;
      @(posedge clk);
      @(negedge clk);
      h = (k - 1) % 800;
      if (!hs_d) begin
        hs_low++;
        if (first_low < 0) first_low = h;
        last_low = h;
      end
      if (ls_d) begin
        ls_cnt++;
        if (ls_cnt == 1) ls_k1 = k;
        if (ls_cnt == 2) ls_k2 = k;
      end
      if (x_d != 9'(h / 2)) x_bad++;
      if (vis_d != (h < 640)) vis_bad_d++;
      if (!vs_d || y_d != 9'd0) vs_bad++;
      if (k == 799) x_798 = x_d;
      if (k == 800) x_799 = x_d;
      if (k == 801) x_800 = x_d;
    end
    check("def_hsync_low_count", 64'(hs_low), 64'd96);
    check("def_hsync_first", 64'(first_low), 64'd656);
    check("def_hsync_last", 64'(last_low), 64'd751);
    check("def_line_start_count", 64'(ls_cnt), 64'd2);
    check("def_line_start_k1", 64'(ls_k1), 64'd1);
    check("def_line_start_k2", 64'(ls_k2), 64'd801);
    check("def_x_sequence", 64'(x_bad), 64'd0);
    check("def_x_at_798", 64'(x_798), 64'd399);
    check("def_x_at_799", 64'(x_799), 64'd399);
    check("def_x_wrap", 64'(x_800), 64'd0);
    check("def_visible_line0", 64'(vis_bad_d), 64'd0);
    check("def_vsync_y_line0", 64'(vs_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/video_timing.md
Name: video_timing

Overview:
- Single-clock VGA raster timing generator; sits directly upstream of the foreground and background stages and the colour output mux.
- Produces the pixel-domain coordinates `current_x`/`current_y` (divided by pixel/line repeat), active-low `hsync`/`vsync`, and blanking and line/frame strobes.
- Defaults give 640x480@60 raster timing, presented as a 320x240 logical grid.

Parameters:
- H_VISIBLE, 640, visible dot clocks per line
- H_FRONT, 16, horizontal front porch (dots)
- H_SYNC, 96, hsync pulse width (dots)
- H_BACK, 48, horizontal back porch (dots)
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- PIXEL_REPEAT, 2, dots per logical pixel (`current_x` divisor)
- LINE_REPEAT, 2, raster lines per logical row (`current_y` divisor)

Ports:
- gpu_clk  in  1  dot clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- current_x  out  9  logical x = h_count / PIXEL_REPEAT, spans whole line incl. blanking
- current_y  out  9  logical y = v_count / LINE_REPEAT, spans whole frame incl. blanking
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- visible  out  1  high when h_count < H_VISIBLE and v_count < V_VISIBLE
- line_start  out  1  one-cycle pulse when h_count == 0
- frame_start  out  1  one-cycle pulse when h_count == 0 and v_count == 0
- frame_count  out  8  frames completed since reset, wraps 255 -> 0

Behaviour:
- Derived values:
  - H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters.
  - MAX_X = ceil(H_TOTAL/PIXEL_REPEAT) - 1; MAX_Y = ceil(V_TOTAL/LINE_REPEAT) - 1.
  - Defaults: H_TOTAL 800, V_TOTAL 525, MAX_X 399, MAX_Y 262.
- Elaboration checks: `$error` if PIXEL_REPEAT < 1, LINE_REPEAT < 1, MAX_X > 511 or MAX_Y > 511.
- h_count:
  - Increments every cycle; wraps H_TOTAL-1 -> 0.
  - When it wraps, v_count increments; v_count wraps V_TOTAL-1 -> 0.
- Repeat counters:
  - x_rep counts 0..PIXEL_REPEAT-1; on its wrap current_x increments.
  - current_x and x_rep both clear when h_count wraps, so a partial last group is truncated.
  - y_rep / current_y behave identically, driven by line wraps and cleared on frame wrap.
  - No division hardware.
  - current_y holds MAX_Y during the final (possibly partial) row group; when V_TOTAL is odd, e.g. 525/2, that group is one raster line long.
- Sync pulses:
  - hsync low when H_VISIBLE+H_FRONT <= h_count < H_VISIBLE+H_FRONT+H_SYNC.
  - vsync low when V_VISIBLE+V_FRONT <= v_count < V_VISIBLE+V_FRONT+V_SYNC.
  - vsync changes only on h_count == 0 boundaries.
- Latency: every output is registered and reflects counter state from the previous cycle (1-cycle latency), so all outputs stay mutually coherent.
- frame_count increments in the same cycle frame_start is asserted, except on the first frame after reset.
- Reset, including mid-line or mid-frame assertion:
  - All counters go to 0; current_x = 0, current_y = 0.
  - hsync = 1, vsync = 1, visible = 0, line_start = 0, frame_start = 0, frame_count = 0.
  - First cycle after release: outputs decode position (0,0), i.e. visible = 1, line_start = 1, frame_start = 1.
- No other state machine beyond the counters; no back-pressure.

Optional Feature:
- Macro: VIDEO_TIMING_VBLANK_IRQ_EN.
- When defined, two extra ports are added:
  - irq_ack  in  1
  - vblank_irq  out  1
- vblank_irq:
  - Sets (registered) on the cycle the outputs show h_count == 0, v_count == V_VISIBLE.
  - Stays high until a cycle with irq_ack = 1.
  - If set and ack occur in the same cycle, set wins.
  - Reset value 0.
- When undefined, both ports and the latch are absent; behaviour is otherwise identical.

Decomposition:
- Package video_timing_pkg holds:
  - the default VGA timing localparams;
  - derived H_TOTAL, V_TOTAL, MAX_X, MAX_Y functions;
  - a typedef for 9-bit coordinates, also consumed by the foreground/background stages.
- One sub-module, wrap_counter: parameterised modulo-N counter with increment-enable, clear and wrap output.
  - Instantiated for h_count, v_count, x_rep, y_rep, current_x and current_y.

Test Plan:
1. Reset, then run 800 cycles:
   - hsync low exactly for h_count 656..751 (96 cycles).
   - line_start pulses at cycles 1 and 801.
   - current_x steps 0,0,1,1,...; reads 399 at h_count 798..799, then 0.
2. Run full frame of 420000 cycles:
   - vsync low for lines 490..491 (1600 cycles).
   - frame_start pulses exactly once per 420000 cycles.
   - frame_count goes 0 -> 1 at the second frame_start.
3. Observe current_y across frame:
   - 0..261 each held 1600 cycles.
   - 262 held 800 cycles (line 524 only), then 0.
   - visible low for all current_y >= 240.
4. Assert rst at line 100, h_count 300 for 3 cycles:
   - Outputs at reset values during rst.
   - After release, (0,0) with frame_start = 1; frame_count = 0.
5. With VIDEO_TIMING_VBLANK_IRQ_EN:
   - vblank_irq rises at line 480, h_count 0, and holds until irq_ack.
   - Ack asserted on the same cycle as the next set leaves vblank_irq = 1.
6. Parameters PIXEL_REPEAT = 1, LINE_REPEAT = 1, all other parameters at default:
   - current_x spans 0..511 with wrap at 799? No: elaboration `$error` (MAX_X = 799 > 511).
   - Confirm the build fails.
